// File: rtl/booth4_csa_seq_if.sv
// Operand/result handshake bundle for the
// sequential radix-4 Booth carry-save multiplier.
interface booth4_csa_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [31:0] out_carry;

  modport master (
    output in_valid,
    input  in_ready,
    output mul_a,
    output mul_b,
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_carry
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  mul_a,
    input  mul_b,
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_carry
  );
endinterface

// File: rtl/booth4_csa_seq.sv
// Sequential radix-4 Booth front end: one digit per
// cycle folded into a 32-bit carry-save pair.
module booth4_csa_seq (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  booth4_csa_seq_if.slave   bus,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q;
  logic [2:0]  cnt_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] sum_q;
  logic [31:0] carry_q;

  logic [16:0] b_ext;
  logic [2:0]  triple;
  logic [17:0] a18;
  logic [17:0] pp18;
  logic [31:0] pp;
  logic [31:0] sum_n;
  logic [31:0] carry_n;
  logic [4:0]  shamt;

  assign shamt  = {cnt_q, 1'b0};
  assign b_ext  = {b_q, 1'b0};
  assign triple = 3'(b_ext >> shamt);
  assign a18    = {{2{a_q[15]}}, a_q};

  // Booth recoding of the current triple
  always_comb begin
    pp18 = '0;
    unique case (1'b1)
      (triple == 3'b001),
      (triple == 3'b010): pp18 = a18;
      (triple == 3'b011): pp18 = a18 << 1;
      (triple == 3'b100): pp18 = -(a18 << 1);
      (triple == 3'b101),
      (triple == 3'b110): pp18 = -a18;
      default:            pp18 = '0;
    endcase
  end

  assign pp = {{14{pp18[17]}}, pp18} << shamt;

  assign sum_n   = sum_q ^ carry_q ^ pp;
  assign carry_n = ((sum_q & carry_q)
                  | (sum_q & pp)
                  | (carry_q & pp)) << 1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.mul_a;
            b_q     <= bus.mul_b;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_n;
          carry_q <= carry_n;
          if (cnt_q == 3'd7) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_carry = carry_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_booth4_csa_seq.sv
// Directed and randomized checks for the
// sequential Booth carry-save multiplier.
module tb_booth4_csa_seq;

  logic sys_clk;
  logic sys_rst_n;
  logic busy;

  booth4_csa_seq_if bus ();

  booth4_csa_seq dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .busy      (busy)
  );

  int total;
  int bad;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_op(
    input string       tag,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [31:0] exp,
    input int          gap,
    input int          stall,
    input bit          noise
  );
    int cyc;
    repeat (gap) tick();
    cyc = 0;
    while (!bus.in_ready && cyc < 30) begin
      tick();
      cyc++;
    end
    chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.mul_a    = a;
    bus.mul_b    = b;
    tick();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      if (cyc == 0) begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".irdy0"},
            32'(bus.in_ready), 32'd0);
      end
      if (noise) begin
        bus.in_valid = 1'($urandom);
        bus.mul_a    = 16'($urandom);
        bus.mul_b    = 16'($urandom);
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".lat"}, 32'(cyc), 32'd8);
    chk({tag, ".res"},
        bus.out_sum + bus.out_carry, exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, ".hold"},
          bus.out_sum + bus.out_carry, exp);
      chk({tag, ".hvld"},
          32'(bus.out_valid), 32'd1);
      chk({tag, ".hrdy"},
          32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, ".ovld0"},
        32'(bus.out_valid), 32'd0);
    chk({tag, ".idle"},
        32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] re;
    total         = 0;
    bad           = 0;
    sys_rst_n     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst.irdy", 32'(bus.in_ready), 32'd1);
    chk("rst.ovld", 32'(bus.out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.sum", bus.out_sum, 32'd0);
    chk("rst.car", bus.out_carry, 32'd0);
    sys_rst_n = 1'b1;
    tick();

    do_op("3x5", 16'd3, 16'd5,
          32'h0000_000F, 0, 0, 1'b0);
    do_op("mnxmn", 16'h8000, 16'h8000,
          32'h4000_0000, 1, 0, 1'b0);
    do_op("mnxmx", 16'h8000, 16'h7FFF,
          32'hC000_8000, 0, 0, 1'b0);
    do_op("m1xm1", 16'hFFFF, 16'hFFFF,
          32'h0000_0001, 2, 0, 1'b0);
    do_op("0xmn", 16'h0000, 16'h8000,
          32'h0000_0000, 0, 0, 1'b0);
    do_op("1234xm1", 16'd1234, 16'hFFFF,
          32'hFFFF_FB2E, 0, 0, 1'b0);
    do_op("stall", 16'd100, 16'hFF9C,
          32'hFFFF_D8F0, 0, 5, 1'b0);
    do_op("noise", 16'h1234, 16'h0056,
          32'h0006_1D78, 0, 0, 1'b1);

    // abort after digit 3 with an async reset
    bus.in_valid = 1'b1;
    bus.mul_a    = 16'h7FFF;
    bus.mul_b    = 16'h1357;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mrst.irdy", 32'(bus.in_ready), 32'd1);
    chk("mrst.ovld", 32'(bus.out_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.sum", bus.out_sum, 32'd0);
    chk("mrst.car", bus.out_carry, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    do_op("7xm9", 16'd7, 16'hFFF7,
          32'hFFFF_FFC1, 0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      re = 32'($signed(ra) * $signed(rb));
      do_op("rnd", ra, rb, re,
            $urandom_range(0, 3),
            $urandom_range(0, 3),
            1'($urandom));
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
